// File: rtl/io_reg_pkg.sv
// Shared constants and helpers for the I/O register bank.
// Parameter limits are checked at elaboration by the bank top.
package io_reg_pkg;

  localparam int MAX_WIDTH       = 32;
  localparam int MAX_SYNC_STAGES = 3;
  localparam int MIN_FILTER_LEN  = 1;
  localparam int MAX_FILTER_LEN  = 255;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  function automatic bit params_ok(input int width, input int sync_stages, input int filter_len);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (sync_stages >= 0) && (sync_stages <= MAX_SYNC_STAGES) &&
           (filter_len >= MIN_FILTER_LEN) && (filter_len <= MAX_FILTER_LEN);
  endfunction

endpackage

// File: rtl/io_reg_bank_if.sv
// Pad/core signal bundle of the I/O register bank.
// master drives pads and core controls; slave is the register bank.
interface io_reg_bank_if #(
  parameter int WIDTH = 8
);
  logic             sync_clr;
  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] in_sel;
  logic             in_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] core_out;
  logic [WIDTH-1:0] core_oe;
  logic             out_en;
  logic [WIDTH-1:0] out_sel;
  logic [WIDTH-1:0] pad_out;
  logic [WIDTH-1:0] pad_oe;

  modport master (
    output sync_clr, pad_in, in_sel, in_en, core_out, core_oe, out_en, out_sel,
    input  data_in, rise, fall, pad_out, pad_oe
  );

  modport slave (
    input  sync_clr, pad_in, in_sel, in_en, core_out, core_oe, out_en, out_sel,
    output data_in, rise, fall, pad_out, pad_oe
  );
endinterface

// File: rtl/io_filter_chan.sv
// One input channel: synchroniser, stability filter and registered edge pulses.
// Accepts a new value after FILTER_LEN consecutive mismatching cycles at the synchroniser output.
module io_filter_chan
  import io_reg_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter logic RST_BIT     = 1'b0
) (
  input  logic CLK,
  input  logic rst,
  input  logic i_sync_clr,
  input  logic i_in_en,
  input  logic i_pad,
  output logic o_filt,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW     = clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] C_LAST = CW'(FILTER_LEN - 1);

  logic          w_s;
  logic          r_filt;
  logic [CW-1:0] r_cnt;
  logic          r_rise;
  logic          r_fall;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_s = i_pad;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
        r_sync <= {SYNC_STAGES{RST_BIT}};
      end else if (i_sync_clr) begin
        r_sync <= {SYNC_STAGES{RST_BIT}};
      end else begin
        r_sync[0] <= i_pad;
        for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];
  end

  // Any cycle where the input matches the accepted value restarts the stability count.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_filt <= RST_BIT;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (i_sync_clr) begin
      r_filt <= RST_BIT;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_in_en) begin
        if (w_s == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
          r_filt <= w_s;
          r_cnt  <= '0;
          r_rise <= w_s;
          r_fall <= ~w_s;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_filt = r_filt;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/io_reg_bank.sv
// Multi-channel pad register bank: filtered inputs with edge pulses, registered outputs/OEs.
// Per-channel select bits bypass either path combinationally, like the single-bit pad cells.
module io_reg_bank
  import io_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILTER_LEN  = 4,
  parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
  input  logic         CLK,
  input  logic         rst,
  io_reg_bank_if.slave bus
);

  localparam bit PARAMS_OK = params_ok(WIDTH, SYNC_STAGES, FILTER_LEN);

  if (!PARAMS_OK) begin : g_param_err
    $error("io_reg_bank: WIDTH must be 1..32, SYNC_STAGES 0..3, FILTER_LEN 1..255");
  end

  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] r_out_q;
  logic [WIDTH-1:0] r_oe_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    io_filter_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .RST_BIT     (RST_VAL[g])
    ) u_chan (
      .CLK        (CLK),
      .rst        (rst),
      .i_sync_clr (bus.sync_clr),
      .i_in_en    (bus.in_en),
      .i_pad      (bus.pad_in[g]),
      .o_filt     (w_filt[g]),
      .o_rise     (w_rise[g]),
      .o_fall     (w_fall[g])
    );
  end

  // OE resets low so the pads come out of reset tri-stated.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_out_q <= RST_VAL;
      r_oe_q  <= '0;
    end else if (bus.sync_clr) begin
      r_out_q <= RST_VAL;
      r_oe_q  <= '0;
    end else if (bus.out_en) begin
      r_out_q <= bus.core_out;
      r_oe_q  <= bus.core_oe;
    end
  end

  assign bus.data_in = (bus.in_sel & bus.pad_in) | (~bus.in_sel & w_filt);
  assign bus.rise    = w_rise;
  assign bus.fall    = w_fall;
  assign bus.pad_out = (bus.out_sel & bus.core_out) | (~bus.out_sel & r_out_q);
  assign bus.pad_oe  = (bus.out_sel & bus.core_oe) | (~bus.out_sel & r_oe_q);

endmodule

// File: tb/tb_io_reg_bank.sv
// Scoreboard bench for io_reg_bank (WIDTH=8, SYNC_STAGES=2, FILTER_LEN=4, RST_VAL=8'hA5).
module tb_io_reg_bank;

  typedef enum int {F_DIN, F_RISE, F_FALL, F_POUT, F_POE} fld_e;

  typedef struct {
    int         cyc;
    fld_e       fld;
    logic [7:0] val;
    string      tag;
  } exp_t;

  logic CLK;
  logic rst;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  exp_t sb[$];

  io_reg_bank_if #(.WIDTH(8)) bus ();

  io_reg_bank #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .FILTER_LEN  (4),
    .RST_VAL     (8'hA5)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] field_val(input fld_e f);
    case (f)
      F_DIN:   return bus.data_in;
      F_RISE:  return bus.rise;
      F_FALL:  return bus.fall;
      F_POUT:  return bus.pad_out;
      default: return bus.pad_oe;
    endcase
  endfunction

  task automatic exp_at(input int c, input fld_e f, input logic [7:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.fld = f;
    e.val = v;
    e.tag = $sformatf("%s@%0d", tag, c);
    sb.push_back(e);
  endtask

  task automatic exp_win(input int c0, input int c1, input fld_e f, input logic [7:0] v,
                         input string tag);
    for (int c = c0; c <= c1; c++) exp_at(c, f, v, tag);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Outputs are sampled mid-cycle, half a period away from the active edge.
  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        check_eq(sb[i].tag, field_val(sb[i].fld), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    int n;
    rst          = 1'b1;
    bus.sync_clr = 1'b0;
    bus.pad_in   = 8'h00;
    bus.in_sel   = 8'h00;
    bus.in_en    = 1'b1;
    bus.core_out = 8'h00;
    bus.core_oe  = 8'h00;
    bus.out_en   = 1'b0;
    bus.out_sel  = 8'h00;

    // Reset values, then release with pads at the reset value: no pulses.
    tick(3);
    exp_at(cyc, F_DIN, 8'hA5, "rst_din");
    exp_at(cyc, F_POE, 8'h00, "rst_poe");
    exp_at(cyc, F_POUT, 8'hA5, "rst_pout");
    exp_at(cyc, F_RISE, 8'h00, "rst_rise");
    exp_at(cyc, F_FALL, 8'h00, "rst_fall");
    bus.pad_in = 8'hA5;
    tick(1);
    rst = 1'b0;
    n = cyc;
    exp_win(n, n + 10, F_RISE, 8'h00, "rel_rise");
    exp_win(n, n + 10, F_FALL, 8'h00, "rel_fall");
    exp_win(n, n + 10, F_DIN, 8'hA5, "rel_din");
    tick(11);

    // Channel 0 falls, then rises: accepted exactly 6 edges after the pad step.
    n = cyc;
    bus.pad_in = 8'hA4;
    exp_win(n, n + 5, F_DIN, 8'hA5, "f0_din_pre");
    exp_at(n + 6, F_DIN, 8'hA4, "f0_din");
    exp_at(n + 6, F_FALL, 8'h01, "f0_fall");
    exp_at(n + 7, F_FALL, 8'h00, "f0_fall_end");
    exp_win(n, n + 7, F_RISE, 8'h00, "f0_rise");
    tick(8);
    n = cyc;
    bus.pad_in = 8'hA5;
    exp_at(n + 5, F_DIN, 8'hA4, "r0_din_pre");
    exp_at(n + 6, F_DIN, 8'hA5, "r0_din");
    exp_at(n + 5, F_RISE, 8'h00, "r0_rise_pre");
    exp_at(n + 6, F_RISE, 8'h01, "r0_rise");
    exp_at(n + 7, F_RISE, 8'h00, "r0_rise_end");
    tick(8);

    // Channel 3 glitch of 3 cycles is rejected; 6 cycles is accepted.
    n = cyc;
    bus.pad_in = 8'hAD;
    exp_win(n, n + 10, F_DIN, 8'hA5, "gl_din");
    exp_win(n, n + 10, F_RISE, 8'h00, "gl_rise");
    exp_win(n, n + 10, F_FALL, 8'h00, "gl_fall");
    tick(3);
    bus.pad_in = 8'hA5;
    tick(8);
    n = cyc;
    bus.pad_in = 8'hAD;
    exp_at(n + 5, F_DIN, 8'hA5, "acc3_din_pre");
    exp_at(n + 6, F_DIN, 8'hAD, "acc3_din");
    exp_at(n + 6, F_RISE, 8'h08, "acc3_rise");
    tick(6);
    n = cyc;
    bus.pad_in = 8'hA5;
    exp_at(n + 6, F_DIN, 8'hA5, "rel3_din");
    exp_at(n + 6, F_FALL, 8'h08, "rel3_fall");
    tick(8);

    // in_en dropped after two counting cycles; accept lands 2 edges after restore.
    n = cyc;
    bus.pad_in = 8'hA7;
    exp_win(n, n + 15, F_DIN, 8'hA5, "frz_din_hold");
    exp_win(n, n + 15, F_RISE, 8'h00, "frz_rise_hold");
    exp_at(n + 16, F_DIN, 8'hA7, "frz_din");
    exp_at(n + 16, F_RISE, 8'h02, "frz_rise");
    tick(4);
    bus.in_en = 1'b0;
    tick(10);
    bus.in_en = 1'b1;
    tick(4);
    n = cyc;
    bus.pad_in = 8'hA5;
    exp_at(n + 6, F_DIN, 8'hA5, "frz_back_din");
    tick(8);

    // Input bypass shows the raw pad at once; edges still follow the filter.
    n = cyc;
    bus.in_sel = 8'h01;
    bus.pad_in = 8'hA4;
    exp_at(n, F_DIN, 8'hA4, "byp_din");
    exp_at(n + 6, F_FALL, 8'h01, "byp_fall");
    exp_at(n + 7, F_DIN, 8'hA4, "byp_din_hold");
    tick(8);
    n = cyc;
    bus.in_sel = 8'h00;
    bus.pad_in = 8'hA5;
    exp_at(n, F_DIN, 8'hA4, "unbyp_din");
    exp_at(n + 6, F_DIN, 8'hA5, "unbyp_din_acc");
    exp_at(n + 6, F_RISE, 8'h01, "unbyp_rise");
    tick(8);

    // Output registers: load, hold, then per-channel bypass.
    n = cyc;
    bus.out_en   = 1'b1;
    bus.core_out = 8'h3C;
    bus.core_oe  = 8'hFF;
    exp_at(n, F_POUT, 8'hA5, "out_pre");
    exp_at(n, F_POE, 8'h00, "oe_pre");
    exp_at(n + 1, F_POUT, 8'h3C, "out_load");
    exp_at(n + 1, F_POE, 8'hFF, "oe_load");
    tick(1);
    n = cyc;
    bus.out_en   = 1'b0;
    bus.core_out = 8'hC3;
    bus.core_oe  = 8'h00;
    exp_win(n, n + 2, F_POUT, 8'h3C, "out_hold");
    exp_win(n, n + 2, F_POE, 8'hFF, "oe_hold");
    tick(3);
    bus.out_sel = 8'h01;
    exp_at(cyc, F_POUT, 8'h3D, "out_byp");
    exp_at(cyc, F_POE, 8'hFE, "oe_byp");
    tick(1);
    bus.out_sel = 8'h00;
    tick(1);

    // sync_clr beats out_en and a pending filter accept on channel 1.
    n = cyc;
    bus.pad_in = 8'hA7;
    tick(5);
    bus.sync_clr = 1'b1;
    bus.out_en   = 1'b1;
    bus.core_out = 8'hFF;
    bus.core_oe  = 8'hFF;
    bus.pad_in   = 8'hA5;
    exp_at(n + 5, F_POUT, 8'h3C, "clr_pout_pre");
    exp_win(n + 6, n + 14, F_DIN, 8'hA5, "clr_din");
    exp_win(n + 6, n + 14, F_RISE, 8'h00, "clr_rise");
    exp_win(n + 6, n + 14, F_FALL, 8'h00, "clr_fall");
    exp_win(n + 6, n + 14, F_POUT, 8'hA5, "clr_pout");
    exp_win(n + 6, n + 14, F_POE, 8'h00, "clr_poe");
    tick(1);
    bus.sync_clr = 1'b0;
    bus.out_en   = 1'b0;
    tick(10);

    check_eq("sb_leftover", 8'(sb.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
